// File: rtl/keccak_nonce_scheduler.sv
// Nonce-range sequencer for one keccak_hasher: issues {nonce, header}
// every THROUGHPUT cycles, tracks in-flight nonces, queues matches.
module keccak_nonce_scheduler #(
  parameter int WIDTH       = 640,
  parameter int NONCE_W     = 32,
  parameter int THROUGHPUT  = 1,
  parameter int INFLIGHT    = 32,
  parameter int FOUND_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       stop,
  input  logic [WIDTH-NONCE_W-1:0]   header,
  input  logic [63:0]                target,
  input  logic [NONCE_W-1:0]         nonce_first,
  input  logic [NONCE_W-1:0]         nonce_last,
  output logic [WIDTH-1:0]           hasher_in,
  output logic                       hasher_read,
  input  logic [255:0]               hash_out,
  input  logic                       hash_write,
  output logic                       found_valid,
  output logic [NONCE_W-1:0]         found_nonce,
  input  logic                       found_ready,
  output logic                       busy,
  output logic                       done,
  output logic                       overflow
);

  localparam int HW  = WIDTH - NONCE_W;
  localparam int TAW = (INFLIGHT > 1) ? $clog2(INFLIGHT) : 1;
  localparam int FAW = (FOUND_DEPTH > 1) ? $clog2(FOUND_DEPTH) : 1;
  localparam int CW  = (THROUGHPUT > 1) ? $clog2(THROUGHPUT) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]         r_state;
  logic [HW-1:0]      r_header;
  logic [63:0]        r_target;
  logic [NONCE_W-1:0] r_last;
  logic [NONCE_W-1:0] r_cur;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_hin;
  logic               r_read;
  logic               r_done;
  logic               r_ovf;

  logic [NONCE_W-1:0] r_tmem [INFLIGHT];
  logic [TAW-1:0]     r_twr;
  logic [TAW-1:0]     r_trd;
  logic [TAW:0]       r_tcnt;

  logic [NONCE_W-1:0] r_fmem [FOUND_DEPTH];
  logic [FAW-1:0]     r_fwr;
  logic [FAW-1:0]     r_frd;
  logic [FAW:0]       r_fcnt;

  logic               w_start;
  logic               w_run_issue;
  logic               w_push_t;
  logic [NONCE_W-1:0] w_push_nonce;
  logic               w_pop_t;
  logic               w_match;
  logic               w_fpop;
  logic               w_ffull;
  logic               w_fpush;
  logic [CW-1:0]      w_cnt_nxt;
  logic               w_unused;

  assign w_unused     = ^hash_out[191:0];
  assign w_start      = (r_state == S_IDLE) && start;
  assign w_run_issue  = (r_state == S_RUN) && (r_cnt == '0) && !stop;
  assign w_push_t     = w_start || w_run_issue;
  assign w_push_nonce = w_start ? nonce_first : r_cur;
  assign w_pop_t      = hash_write && (r_tcnt != '0);
  assign w_match      = w_pop_t && (hash_out[255:192] <= r_target);
  assign w_fpop       = found_valid && found_ready;
  assign w_ffull      = (r_fcnt == (FAW+1)'(FOUND_DEPTH));
  assign w_fpush      = w_match && (!w_ffull || w_fpop);
  assign w_cnt_nxt    = (r_cnt == CW'(THROUGHPUT-1)) ? '0 : r_cnt + 1'b1;

  assign hasher_in   = r_hin;
  assign hasher_read = r_read;
  assign found_valid = (r_fcnt != '0);
  assign found_nonce = r_fmem[r_frd];
  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign overflow    = r_ovf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_header <= '0;
      r_target <= '0;
      r_last   <= '0;
      r_cur    <= '0;
      r_cnt    <= '0;
      r_hin    <= '0;
      r_read   <= 1'b0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_read <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_header <= header;
          r_target <= target;
          r_last   <= nonce_last;
          r_cur    <= nonce_first + 1'b1;
          r_cnt    <= CW'(THROUGHPUT > 1);
          r_read   <= 1'b1;
          r_hin    <= {nonce_first, header};
          r_ovf    <= 1'b0;
          // a reversed or single-nonce range issues only nonce_first
          r_state  <= (nonce_last <= nonce_first) ? S_DRAIN : S_RUN;
        end
        S_RUN: begin
          r_cnt <= w_cnt_nxt;
          if (stop) begin
            r_state <= S_DRAIN;
          end else if (w_run_issue) begin
            r_read <= 1'b1;
            r_hin  <= {r_cur, r_header};
            r_cur  <= r_cur + 1'b1;
            if (r_cur == r_last) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: if ((r_tcnt == '0) && !hash_write) begin
          r_state <= S_IDLE;
          r_done  <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_match && w_ffull && !w_fpop) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_twr  <= '0;
      r_trd  <= '0;
      r_tcnt <= '0;
    end else begin
      assert (!(w_push_t && !w_pop_t &&
                r_tcnt == (TAW+1)'(INFLIGHT)));
      if (w_push_t)
        r_twr <= (r_twr == TAW'(INFLIGHT-1)) ? '0 : r_twr + 1'b1;
      if (w_pop_t)
        r_trd <= (r_trd == TAW'(INFLIGHT-1)) ? '0 : r_trd + 1'b1;
      r_tcnt <= r_tcnt + {{TAW{1'b0}}, w_push_t}
                       - {{TAW{1'b0}}, w_pop_t};
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_t) r_tmem[r_twr] <= w_push_nonce;
    if (w_fpush)  r_fmem[r_fwr] <= r_tmem[r_trd];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fwr  <= '0;
      r_frd  <= '0;
      r_fcnt <= '0;
    end else begin
      if (w_fpush) r_fwr <= r_fwr + 1'b1;
      if (w_fpop)  r_frd <= r_frd + 1'b1;
      r_fcnt <= r_fcnt + {{FAW{1'b0}}, w_fpush}
                       - {{FAW{1'b0}}, w_fpop};
    end
  end

endmodule
